// File: rtl/gray_conv3x3_filter.sv
// Streaming RGB-to-gray conversion followed by a 3x3 Sobel gradient stage.
// Fixed four-cycle latency, one result per accepted pixel, no backpressure.
module gray_conv3x3_filter #(
    parameter int DATA_W = 12,
    parameter int IMG_W  = 640
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_red,
    input  logic [DATA_W-1:0] i_green,
    input  logic [DATA_W-1:0] i_blue,
    input  logic              i_valid,
    input  logic              i_sof,
    input  logic [1:0]        i_mode,
    output logic [DATA_W-1:0] o_red,
    output logic [DATA_W-1:0] o_green,
    output logic [DATA_W-1:0] o_blue,
    output logic              o_valid,
    output logic              o_sof
);

    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 2;
    localparam int GW = DATA_W + 3;
    localparam int SW = DATA_W + 4;
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [SW-1:0] SAT_MAX = {4'b0000, {DATA_W{1'b1}}};

    // frame tracking
    logic              r_sync;
    logic [CW-1:0]     r_col;
    logic [1:0]        r_row;
    logic [1:0]        r_mode;

    // stage 1
    logic              r1_vld;
    logic              r1_sof;
    logic [DATA_W-1:0] r1_gray;
    logic [CW-1:0]     r1_col;
    logic [1:0]        r1_mode;
    logic              r1_bdr;

    // stage 2
    logic              r2_vld;
    logic              r2_sof;
    logic [DATA_W-1:0] r2_gray;
    logic [1:0]        r2_mode;
    logic              r2_bdr;
    logic [DATA_W-1:0] r_lb0 [IMG_W];
    logic [DATA_W-1:0] r_lb1 [IMG_W];
    logic [DATA_W-1:0] r_wt [3];
    logic [DATA_W-1:0] r_wm [3];
    logic [DATA_W-1:0] r_wb [3];

    // stage 3
    logic              r3_vld;
    logic              r3_sof;
    logic [DATA_W-1:0] r3_gray;
    logic [1:0]        r3_mode;
    logic              r3_bdr;
    logic [SW-1:0]     r3_gx;
    logic [SW-1:0]     r3_gy;

    // stage 0 combinational
    logic [GW-1:0]     w_sum;
    logic [DATA_W-1:0] w_gray;
    logic              w_acc;
    logic [CW-1:0]     w_col;
    logic [CW-1:0]     w_col_nxt;
    logic [1:0]        w_row;
    logic [1:0]        w_row_nxt;
    logic [1:0]        w_mode;
    logic              w_last;

    // stage 2/3 combinational
    logic [SW-1:0]        w_gxp;
    logic [SW-1:0]        w_gxn;
    logic [SW-1:0]        w_gyp;
    logic [SW-1:0]        w_gyn;
    logic signed [SW-1:0] w_gx;
    logic signed [SW-1:0] w_gy;
    logic [SW-1:0]        w_gxa;
    logic [SW-1:0]        w_gya;

    // stage 3/4 combinational
    logic [SW-1:0]     w_mag;
    logic [DATA_W-1:0] w_sat;
    logic [DATA_W-1:0] w_res;

    // pixels before the first SOF after reset are dropped
    always_comb begin
        w_sum = (GW'(i_red) << 1) + GW'(i_red)
              + (GW'(i_green) << 1) + GW'(i_green)
              + (GW'(i_blue) << 1);
        w_gray    = DATA_W'(w_sum >> 3);
        w_acc     = i_valid & (i_sof | r_sync);
        w_col     = i_sof ? '0 : r_col;
        w_row     = i_sof ? 2'd0 : r_row;
        w_mode    = i_sof ? i_mode : r_mode;
        w_last    = (w_col == LAST_COL);
        w_col_nxt = w_last ? '0 : w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_last && w_row != 2'd2) begin
            w_row_nxt = w_row + 2'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync <= 1'b0;
            r_col  <= '0;
            r_row  <= 2'd0;
            r_mode <= 2'd0;
            r1_vld <= 1'b0;
            r1_sof <= 1'b0;
            r2_vld <= 1'b0;
            r2_sof <= 1'b0;
            r3_vld <= 1'b0;
            r3_sof <= 1'b0;
        end else begin
            r1_vld <= w_acc;
            r1_sof <= w_acc & i_sof;
            r2_vld <= r1_vld;
            r2_sof <= r1_sof;
            r3_vld <= r2_vld;
            r3_sof <= r2_sof;
            if (w_acc) begin
                r_sync <= 1'b1;
                r_col  <= w_col_nxt;
                r_row  <= w_row_nxt;
                r_mode <= w_mode;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_acc) begin
            r1_gray <= w_gray;
            r1_col  <= w_col;
            r1_mode <= w_mode;
            r1_bdr  <= (w_row != 2'd2) || (w_col < CW'(2));
        end
    end

    // line buffers and window need no reset: border masking hides stale data
    always_ff @(posedge i_clk) begin
        if (r1_vld) begin
            r_lb0[r1_col] <= r1_gray;
            r_lb1[r1_col] <= r_lb0[r1_col];
            r_wt[0]  <= r_wt[1];
            r_wt[1]  <= r_wt[2];
            r_wt[2]  <= r_lb1[r1_col];
            r_wm[0]  <= r_wm[1];
            r_wm[1]  <= r_wm[2];
            r_wm[2]  <= r_lb0[r1_col];
            r_wb[0]  <= r_wb[1];
            r_wb[1]  <= r_wb[2];
            r_wb[2]  <= r1_gray;
            r2_gray  <= r1_gray;
            r2_mode  <= r1_mode;
            r2_bdr   <= r1_bdr;
        end
    end

    always_comb begin
        w_gxp = SW'(r_wt[2]) + (SW'(r_wm[2]) << 1) + SW'(r_wb[2]);
        w_gxn = SW'(r_wt[0]) + (SW'(r_wm[0]) << 1) + SW'(r_wb[0]);
        w_gyp = SW'(r_wb[0]) + (SW'(r_wb[1]) << 1) + SW'(r_wb[2]);
        w_gyn = SW'(r_wt[0]) + (SW'(r_wt[1]) << 1) + SW'(r_wt[2]);
        w_gx  = $signed(w_gxp - w_gxn);
        w_gy  = $signed(w_gyp - w_gyn);
        w_gxa = w_gx[SW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
        w_gya = w_gy[SW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    end

    always_ff @(posedge i_clk) begin
        if (r2_vld) begin
            r3_gx   <= w_gxa;
            r3_gy   <= w_gya;
            r3_gray <= r2_gray;
            r3_mode <= r2_mode;
            r3_bdr  <= r2_bdr;
        end
    end

    always_comb begin
        w_mag = '0;
        case (r3_mode)
            2'd1:    w_mag = r3_gx;
            2'd2:    w_mag = r3_gy;
            2'd3:    w_mag = r3_gx + r3_gy;
            default: w_mag = '0;
        endcase
        w_sat = (w_mag > SAT_MAX) ? {DATA_W{1'b1}} : DATA_W'(w_mag);
        w_res = w_sat;
        if (r3_mode == 2'd0) begin
            w_res = r3_gray;
        end else if (r3_bdr) begin
            w_res = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_red   <= '0;
            o_green <= '0;
            o_blue  <= '0;
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
        end else begin
            o_valid <= r3_vld;
            o_sof   <= r3_vld & r3_sof;
            if (r3_vld) begin
                o_red   <= w_res;
                o_green <= w_res;
                o_blue  <= w_res;
            end
        end
    end

endmodule
